// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array.
// Sequence: clear the PEs, feed skewed operand lanes, let the wavefront
// drain, then stream the N*N results out row-major over valid/ready.
// Handshake: a result is transferred in a cycle where res_valid and
// res_ready are both high; res_valid never drops and rd_row/rd_col never
// change while a presented result is waiting for res_ready.
module systolic_seq_ctrl #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pe_clr_n,
    output logic [N-1:0]   feed_en,
    output logic [8*N-1:0] feed_idx,
    output logic [7:0]     rd_row,
    output logic [7:0]     rd_col,
    output logic           res_valid,
    input  logic           res_ready
);

    // t counts from the first feed cycle up to the end of the drain,
    // so it must hold K+2N-3 (at most 284) without overflow.
    localparam int TW = 9;
    localparam logic [TW-1:0] FEED_LAST  = TW'(K + N - 2);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(K + 2 * N - 3);
    localparam logic [7:0]    LAST_IDX   = 8'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_READ
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic          done_q, done_d;

    // Next-state and counter logic for the whole sequence.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                end
                t_d = t_q + 1'b1;
            end
            S_DRAIN: begin
                if (t_q == DRAIN_LAST) begin
                    state_d = S_READ;
                    t_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_READ: begin
                if (res_ready) begin
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            row_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    // Output decode from registered state; rst forces the reset values.
    always_comb begin
        busy      = !rst && (state_q != S_IDLE);
        done      = !rst && done_q;
        pe_clr_n  = !rst && (state_q != S_CLEAR);
        res_valid = !rst && (state_q == S_READ);
        rd_row    = rst ? 8'd0 : row_q;
        rd_col    = rst ? 8'd0 : col_q;
        feed_en   = '0;
        feed_idx  = '0;
        for (int i = 0; i < N; i++) begin
            // Lane i is live for K cycles starting at t = i.
            if (!rst && (state_q == S_FEED) &&
                (t_q >= TW'(i)) && (t_q <= TW'(i + K - 1))) begin
                feed_en[i]        = 1'b1;
                feed_idx[8*i +: 8] = 8'(t_q - TW'(i));
            end
        end
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of MAC processing elements.
- Each PE accumulates north*west on every clock and forwards its operands south/east one cycle later; its accumulator clears when its active-low reset is driven low.
- This block clears the array, generates skewed per-lane operand-feed enables and inner-dimension indices for the external A/B operand buffers, waits for the wavefront to drain, then streams out the N*N results with a valid/ready handshake.

Parameters:
- N, 4, array dimension (rows = columns); legal range 2..16.
- K, 4, inner (reduction) dimension length; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one matrix multiply; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on return to IDLE after the last result is accepted.
- pe_clr_n  output  1  active-low clear to every PE reset input.
- feed_en  output  N  bit i high means lane i (row i of A on the west edge, column i of B on the north edge) carries a valid operand. The feeder must drive 0 on any lane whose bit is low.
- feed_idx  output  8*N  packed per-lane k index; lane i occupies bits [8i+7:8i]. Value is 0 when that lane is disabled.
- rd_row  output  8  result row select for the external result mux.
- rd_col  output  8  result column select for the external result mux.
- res_valid  output  1  the result selected by rd_row/rd_col is valid.
- res_ready  input  1  downstream accepts the result when res_valid and res_ready are both high.

Behaviour:
- States: IDLE, CLEAR, FEED, DRAIN, READ.
- Registered state and counters; all outputs are decoded from the registered state.
  - Buffers read combinationally in the same cycle.
- Reset values (applied while rst=1, from any state, including mid-operation):
  - State goes to IDLE; all counters are 0.
  - busy=0, done=0, pe_clr_n=0, feed_en=0, feed_idx=0, rd_row=0, rd_col=0, res_valid=0.
  - A partial multiply is abandoned: no done pulse and no results.
- IDLE:
  - pe_clr_n=1.
  - start=1 moves to CLEAR. start=0 stays in IDLE.
  - start is ignored in every other state; no queuing.
- CLEAR: exactly 1 cycle. pe_clr_n=0, then go to FEED with t=0.
- FEED: t runs from 0 to K+N-2 (K+N-1 cycles).
  - feed_en[i]=1 iff i <= t <= i+K-1.
  - feed_idx lane i = t-i when enabled, else 0.
  - After t=K+N-2, go to DRAIN.
- DRAIN: N-1 cycles with feed_en=0 and feed_idx=0.
  - The last product reaches PE(N-1,N-1) in the cycle t=K+2N-3 overall.
  - Then go to READ with rd_row=rd_col=0.
- READ: res_valid=1.
  - Scan order is row-major: rd_col increments, wraps at N-1 to 0, and then rd_row increments.
  - Advance only on res_valid & res_ready.
  - While res_ready=0, rd_row/rd_col/res_valid hold stable.
  - Acceptance of (N-1,N-1) moves to IDLE.
  - feed_en stays 0 throughout, so PE accumulators hold.
- done: registered; equals 1 in the first IDLE cycle after READ completes.
  - A start in that same cycle is accepted.
- Latency with res_ready held high: done is asserted K+N*N+2N cycles after the cycle in which start is sampled.
- Counter widths cover K+2N and N-1 without overflow. No arithmetic is performed on data (PE results are not touched by this block).

Test Plan:
- N=4,K=4; start pulse at cycle 0, res_ready=1 -> busy=1 from cycle 1; pe_clr_n=0 only in cycle 1; FEED cycles 2-8; DRAIN 9-11; res_valid cycles 12-27; done=1 in cycle 28 only; busy=0 in cycle 28.
- Feed skew, N=4,K=4 -> feed_en at t=0..6 = 0001, 0011, 0111, 1111, 1110, 1100, 1000; at t=6 lane3 idx=3 and lanes0-2 idx=0; at t=3 lane0 idx=3, lane3 idx=0.
- End-to-end with a 4x4 PE array model, A=[[1,2,3,4]...] (row i = i*4+1..i*4+4), B=identity -> the 16 read-out values equal A in row-major order.
- Backpressure: hold res_ready=0 for 5 cycles at rd_row=1, rd_col=2 -> outputs stable for 5 cycles, no skipped or repeated index after release; done delayed by exactly 5 cycles (cycle 33).
- Assert rst for 1 cycle during FEED at t=3 -> next cycle IDLE, all outputs at reset values, no done; a new start then runs a full 28-cycle sequence.
- start held high continuously -> start ignored while busy; a second run begins in the done cycle (CLEAR in cycle 29).
